tdc_raw_emulator: RTL
=====================

# tdc_raw_emulator

Converts 12-bit TDC binary codes back into raw TDC front-end words: a 55-bit ring-oscillator thermometer fine code plus the two 5-bit coarse ripple counters A and B. It is the inverse of the TDC encoder. It feeds encoder benches and on-chip loopback self-test with raw words whose encoded value is known exactly. Codes enter through a 4-entry FIFO and are decoded by a multi-cycle subtract FSM. Raw words leave on a valid/ready handshake.

## Interface
- `FIFO_DEPTH`, default 4: input FIFO entries; must be a power of 2.
- `FINE_STEPS`, default 110: fine phases per coarse count; always 2×55.
- `clk40M` in 1: 40 MHz clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `code_in` in 12: TDC binary code.
- `code_valid` in 1: `code_in` valid.
- `code_ready` out 1: FIFO can accept a code.
- `fine_raw_code` out 55: thermometer fine code.
- `counterA` out 5: coarse counter A.
- `counterB` out 5: coarse counter B.
- `raw_valid` out 1: raw word valid.
- `raw_ready` in 1: sink accepts the raw word.
- `code_err` out 1: one-cycle pulse when an invalid code is dropped.
- `err_cnt` out 8: invalid-code count; only present with `TDC_EMU_ERRCNT_EN`.

## Operation
- **Code mapping:** code = coarse×110 + f.
  - coarse is 0..31 and f is 0..109.
  - Valid codes are 0..3519. Codes 3520..4095 are invalid.
- **Fine code:**
  - f in 0..54: bits [f-1:0] = 1, all other bits 0. f = 0 gives all zeros.
  - f in 55..109: bits [f-56:0] = 0, all other bits 1. f = 55 gives all ones.
- **Counters:**
  - `counterA` = coarse.
  - `counterB` = (coarse−1) mod 32 when f < 55; otherwise `counterB` = coarse.
- **FIFO:**
  - A push occurs on `code_valid && code_ready`.
  - `code_ready` is registered and equals !full on the next cycle.
  - A push into an empty FIFO is visible to the FSM one cycle later.
- **FSM** (IDLE, DIV, OUT):
  - IDLE: if the FIFO is non-empty, pop it.
    - If the popped code is 3520 or more: pulse `code_err`, drop the code, and stay in IDLE.
    - Otherwise load rem = code and coarse = 0, then go to DIV.
  - DIV: while rem ≥ 110, subtract 110 from rem and increment coarse, one subtraction per cycle.
    - When rem < 110, register `fine_raw_code`, `counterA` and `counterB` from (coarse, rem), assert `raw_valid`, and go to OUT.
  - OUT: hold all outputs stable while `raw_ready` is low. On `raw_valid && raw_ready`, deassert `raw_valid` and return to IDLE.
- Data on the raw outputs holds its last value after a handshake; it is not cleared.
- Arithmetic:
  - rem is 12 bits unsigned and never underflows.
  - coarse is 5 bits and cannot exceed 31 for valid codes.

## Timing
- **Reset values:**
  - Outputs: `code_ready`=0, `raw_valid`=0, `fine_raw_code`=0, `counterA`=0, `counterB`=0, `code_err`=0, `err_cnt`=0.
  - Internal: FIFO empty, FSM in IDLE.
  - `code_ready` rises on the first edge after `rst_n` deasserts.
- **Latency:** with a pop at edge k, `raw_valid` is high after edge k+coarse+1.
  - Minimum 1 edge (coarse 0); maximum 32 edges (coarse 31).
- **Throughput:** back-to-back words with `raw_ready` held high need coarse+3 cycles each.
- **Full:** `code_ready` drops one cycle after the accepting push that fills the FIFO.
  - A push and a pop in the same cycle on a full FIFO leave it full.
- **Empty:** the FSM stays in IDLE and no pop occurs.
- **Invalid codes:** `code_err` is high for exactly one cycle per dropped code.
  - Back-to-back invalid codes give one pulse per cycle.
- **Reset mid-operation:** asynchronous clear of everything.
  - Partially decoded codes and FIFO contents are lost.
  - `raw_valid` drops immediately.

## Configuration
- `TDC_EMU_ERRCNT_EN` defined: the `err_cnt` port exists.
  - It increments on each `code_err` pulse and saturates at 255.
  - It is cleared only by reset.
- Macro undefined: no `err_cnt` port and no counter logic. `code_err` is unaffected.

## Test plan
- **Code 52:** push 52 with `raw_ready`=1 → `raw_valid` 1 edge after pop, with:
  - `fine_raw_code` = 55'h0F_FFFF_FFFF_FFFF
  - `counterA` = 0
  - `counterB` = 31
- **Codes 165 and 3519:** push 165 then 3519.
  - 165 → all-ones fine code (55'h7F_FFFF_FFFF_FFFF), `counterA` = 1, `counterB` = 1.
  - 3519 → 55'h40_0000_0000_0000, `counterA` = 31, `counterB` = 31. Latency is 32 edges.
- **Invalid then valid:** push 3520 then 0.
  - One `code_err` pulse; `err_cnt` = 1 when the macro is defined.
  - Next word: all-zero fine code, `counterA` = 0, `counterB` = 31.
- **Backpressure:** hold `raw_ready`=0 and offer 6 codes back-to-back.
  - Exactly 5 are accepted: 1 in OUT plus 4 in the FIFO. `code_ready` then stays 0.
  - Release `raw_ready` → all 5 words emerge in push order and outputs are stable while stalled.
- **Reset mid-DIV:** push 3000 and assert `rst_n`=0 at the 10th DIV cycle.
  - All outputs return to their reset values immediately.
  - After release, push 1 → `raw_valid` with `fine_raw_code` = 55'h00_0000_0000_0001.
- **Saturation** (macro defined): push 300 invalid codes → `err_cnt` = 255.

Source files
------------

// File: rtl/tdc_raw_emulator.sv
// tdc_raw_emulator
// Inverse of the TDC encoder. It turns 12-bit TDC binary codes
// (code = coarse*FINE_STEPS + f) back into raw front-end words: a
// thermometer fine code plus the two coarse ripple counters A and B.
// Codes are buffered in a small FIFO. A subtract FSM (IDLE/DIV/OUT)
// performs one subtraction of FINE_STEPS per cycle to recover the
// coarse count. Raw words leave on a valid/ready handshake.
//
// Parameters:
//   FIFO_DEPTH    input FIFO entries (power of 2, default 4)
//   FINE_STEPS    fine phases per coarse count (2x fine code width, default 110)
// Ports:
//   clk40M        clock, rising edge
//   rst_n         asynchronous active-low reset
//   code_in       12-bit TDC code, qualified by code_valid
//   code_ready    registered FIFO-not-full flag
//   fine_raw_code thermometer fine code (FINE_STEPS/2 bits)
//   counterA/B    coarse counters
//   raw_valid     raw word valid; the sink accepts it with raw_ready
//   code_err      one-cycle pulse for each invalid code that is dropped
//   err_cnt       saturating invalid-code count; the port exists only
//                 when TDC_EMU_ERRCNT_EN is defined
module tdc_raw_emulator #(
  parameter int FIFO_DEPTH = 4,
  parameter int FINE_STEPS = 110
) (
  input  logic                      clk40M,
  input  logic                      rst_n,
  input  logic [11:0]               code_in,
  input  logic                      code_valid,
  output logic                      code_ready,
  output logic [FINE_STEPS/2-1:0]   fine_raw_code,
  output logic [4:0]                counterA,
  output logic [4:0]                counterB,
  output logic                      raw_valid,
  input  logic                      raw_ready,
  output logic                      code_err
`ifdef TDC_EMU_ERRCNT_EN
  ,
  output logic [7:0]                err_cnt
`endif
);

  localparam int AW     = $clog2(FIFO_DEPTH);
  localparam int CW     = AW + 1;
  localparam int FINE_W = FINE_STEPS / 2;
  localparam logic [11:0] STEP       = 12'(FINE_STEPS);
  localparam logic [11:0] HALF       = 12'(FINE_W);
  localparam logic [11:0] CODE_LIMIT = 12'(32 * FINE_STEPS);
  localparam logic [CW-1:0] CNT_FULL = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DIV  = 2'd1,
    S_OUT  = 2'd2
  } state_t;

  // Thermometer fine code. The first half of the phases fills ones from
  // bit 0 upward. The second half clears bits from bit 0 upward, so f == HALF is all ones.
  function automatic logic [FINE_W-1:0] fine_therm(input logic [11:0] f);
    logic [FINE_W-1:0] t;
    t = '0;
    for (int i = 0; i < FINE_W; i++) begin
      if (f < HALF) begin
        t[i] = (12'(i) < f);
      end else begin
        t[i] = (12'(i) >= (f - HALF));
      end
    end
    return t;
  endfunction

  // FIFO storage and pointers
  logic [11:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]  count_q, count_d;
  logic           code_ready_q;
  logic           push_s, pop_s, empty_s;
  logic [11:0]    head_s;

  // FSM and output registers
  state_t              state_q, state_d;
  logic [11:0]         rem_q, rem_d;
  logic [4:0]          coarse_q, coarse_d;
  logic [FINE_W-1:0]   fine_q, fine_d;
  logic [4:0]          cnta_q, cnta_d;
  logic [4:0]          cntb_q, cntb_d;
  logic                raw_valid_q, raw_valid_d;
  logic                code_err_q, code_err_d;

  // code_ready_q always matches the current count, so a push can never overflow the FIFO.
  assign push_s  = code_valid && code_ready_q;
  assign empty_s = (count_q == '0);
  assign head_s  = mem_q[rd_ptr_q];

  // FIFO occupancy next state
  always_comb begin
    count_d = count_q;
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // FIFO registers; code_ready is the registered !full of the next count
  always_ff @(posedge clk40M or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= 12'd0;
      end
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      code_ready_q <= 1'b0;
    end else begin
      if (push_s) begin
        mem_q[wr_ptr_q] <= code_in;
        wr_ptr_q        <= wr_ptr_q + AW'(1);
      end
      if (pop_s) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      count_q      <= count_d;
      code_ready_q <= (count_d != CNT_FULL);
    end
  end

  // Decode FSM next-state and output next-state
  always_comb begin
    state_d     = state_q;
    rem_d       = rem_q;
    coarse_d    = coarse_q;
    fine_d      = fine_q;
    cnta_d      = cnta_q;
    cntb_d      = cntb_q;
    raw_valid_d = raw_valid_q;
    code_err_d  = 1'b0;
    pop_s       = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!empty_s) begin
          pop_s = 1'b1;
          if (head_s >= CODE_LIMIT) begin
            code_err_d = 1'b1;
          end else begin
            rem_d    = head_s;
            coarse_d = 5'd0;
            state_d  = S_DIV;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_DIV: begin
        if (rem_q >= STEP) begin
          rem_d    = rem_q - STEP;
          coarse_d = coarse_q + 5'd1;
        end else begin
          fine_d      = fine_therm(rem_q);
          cnta_d      = coarse_q;
          // Counter B lags counter A by one in the first half of the fine phases.
          cntb_d      = (rem_q < HALF) ? (coarse_q - 5'd1) : coarse_q;
          raw_valid_d = 1'b1;
          state_d     = S_OUT;
        end
      end
      S_OUT: begin
        if (raw_ready) begin
          raw_valid_d = 1'b0;
          state_d     = S_IDLE;
        end else begin
          state_d = S_OUT;
        end
      end
      default: begin
        raw_valid_d = 1'b0;
        state_d     = S_IDLE;
      end
    endcase
  end

  // FSM state, work registers and registered raw outputs
  always_ff @(posedge clk40M or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      rem_q       <= 12'd0;
      coarse_q    <= 5'd0;
      fine_q      <= '0;
      cnta_q      <= 5'd0;
      cntb_q      <= 5'd0;
      raw_valid_q <= 1'b0;
      code_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      rem_q       <= rem_d;
      coarse_q    <= coarse_d;
      fine_q      <= fine_d;
      cnta_q      <= cnta_d;
      cntb_q      <= cntb_d;
      raw_valid_q <= raw_valid_d;
      code_err_q  <= code_err_d;
    end
  end

  assign code_ready    = code_ready_q;
  assign fine_raw_code = fine_q;
  assign counterA      = cnta_q;
  assign counterB      = cntb_q;
  assign raw_valid     = raw_valid_q;
  assign code_err      = code_err_q;

`ifdef TDC_EMU_ERRCNT_EN
  logic [7:0] err_cnt_q, err_cnt_d;

  // Saturating invalid-code counter, updated on the same edge as the code_err pulse
  always_comb begin
    if (code_err_d && (err_cnt_q != 8'hFF)) begin
      err_cnt_d = err_cnt_q + 8'd1;
    end else begin
      err_cnt_d = err_cnt_q;
    end
  end

  // Error counter register, cleared only by reset
  always_ff @(posedge clk40M or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt_q <= 8'd0;
    end else begin
      err_cnt_q <= err_cnt_d;
    end
  end

  assign err_cnt = err_cnt_q;
`endif

endmodule
